// File: rtl/sub_s_serial.sv
// Bit-serial signed subtractor: diff = x - y computed LSB first as x + ~y + 1,
// one bit per clock, with positive (of) and negative (uf) overflow flags.
module sub_s_serial #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             of,
   output logic             uf
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

   state_t           state_q, state_d;
   logic [WIDTH-1:0] xs_q, xs_d;
   logic [WIDTH-1:0] ys_q, ys_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             c_q, c_d;
   logic             xm_q, xm_d;
   logic             ym_q, ym_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic             of_q, of_d;
   logic             uf_q, uf_d;
   logic             sum_s;

   // State and datapath registers, synchronous reset has top priority
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         xs_q    <= {WIDTH{1'b0}};
         ys_q    <= {WIDTH{1'b0}};
         res_q   <= {WIDTH{1'b0}};
         cnt_q   <= {CNT_W{1'b0}};
         c_q     <= 1'b0;
         xm_q    <= 1'b0;
         ym_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         diff_q  <= {WIDTH{1'b0}};
         of_q    <= 1'b0;
         uf_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         xs_q    <= xs_d;
         ys_q    <= ys_d;
         res_q   <= res_d;
         cnt_q   <= cnt_d;
         c_q     <= c_d;
         xm_q    <= xm_d;
         ym_q    <= ym_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         diff_q  <= diff_d;
         of_q    <= of_d;
         uf_q    <= uf_d;
      end
   end

   // Next-state logic: one full-adder step on the current LSBs per SHIFT cycle
   always_comb begin
      state_d = state_q;
      xs_d    = xs_q;
      ys_d    = ys_q;
      res_d   = res_q;
      cnt_d   = cnt_q;
      c_d     = c_q;
      xm_d    = xm_q;
      ym_d    = ym_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      diff_d  = diff_q;
      of_d    = of_q;
      uf_d    = uf_q;
      sum_s   = xs_q[0] ^ ~ys_q[0] ^ c_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               xs_d    = x;
               ys_d    = y;
               xm_d    = x[WIDTH-1];
               ym_d    = y[WIDTH-1];
               c_d     = 1'b1;
               cnt_d   = {CNT_W{1'b0}};
               busy_d  = 1'b1;
               state_d = SHIFT;
            end else begin
               state_d = IDLE;
            end
         end
         SHIFT: begin
            res_d = {sum_s, res_q[WIDTH-1:1]};
            xs_d  = {1'b0, xs_q[WIDTH-1:1]};
            ys_d  = {1'b0, ys_q[WIDTH-1:1]};
            c_d   = maj3(xs_q[0], ~ys_q[0], c_q);
            cnt_d = cnt_q + CNT_W'(1);
            // The final sum bit is the result sign, so flags use it directly
            if (cnt_q == LAST_BIT) begin
               state_d = IDLE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               diff_d  = {sum_s, res_q[WIDTH-1:1]};
               of_d    = ~xm_q & ym_q & sum_s;
               uf_d    = xm_q & ~ym_q & ~sum_s;
               cnt_d   = {CNT_W{1'b0}};
            end else begin
               state_d = SHIFT;
            end
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   assign busy = busy_q;
   assign done = done_q;
   assign diff = diff_q;
   assign of   = of_q;
   assign uf   = uf_q;

endmodule
